// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit serializer.
// Sends one byte as an asynchronous frame on tx: start bit, 5..8 data bits
// LSB first, optional parity bit, then one or two stop bits. Bit timing is set
// by the external one-cycle baud_tick strobe. The frame format and the payload
// are captured when the frame is accepted, so later changes to the inputs do
// not affect a frame already in flight.
//
// Optional feature, macro UART_TX_BREAK_EN: adds input tx_break. While it is
// high in IDLE, tx is held low (line break) and tx_enable is ignored.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle (tx=1, or 0 during a break); waiting for tx_enable
// S_START  | start bit on the line until the next baud_tick
// S_DATA   | data bit shadow_data[bit_cnt] on the line
// S_PARITY | parity bit on the line (only when parity is enabled)
// S_STOP1  | first stop bit
// S_STOP2  | second stop bit (only when two stop bits are configured)

module uart_tx_frame (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_tick,
   input  logic       tx_enable,
   input  logic [4:0] cfg_reg,
   input  logic [7:0] tx_data,
`ifdef UART_TX_BREAK_EN
   input  logic       tx_break,
`endif
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
   } state_t;

   state_t     state;
   logic [7:0] shadow_data;
   logic [4:0] shadow_cfg;
   logic [2:0] bit_cnt;

   logic [2:0] last_bit;
   logic [2:0] next_cnt;
   logic [7:0] unused_hi;
   logic [7:0] data_masked;
   logic       parity_bit;
   logic       brk;

`ifdef UART_TX_BREAK_EN
   assign brk = tx_break;
`else
   assign brk = 1'b0;
`endif

   // Index of the final data bit: N-1 = 4 + length code.
   assign last_bit    = {1'b1, shadow_cfg[1:0]};
   assign next_cnt    = bit_cnt + 3'd1;
   // Bits above the configured length are excluded from the parity.
   assign unused_hi   = 8'hE0 << shadow_cfg[1:0];
   assign data_masked = shadow_data & ~unused_hi;
   // Even parity is the XOR of the data bits; odd parity inverts it.
   assign parity_bit  = (^data_masked) ^ shadow_cfg[4];

   // Frame sequencer with registered line, busy and done outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         shadow_data <= 8'h00;
         shadow_cfg  <= 5'h00;
         bit_cnt     <= 3'd0;
         tx          <= 1'b1;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (brk) begin
                  tx <= 1'b0;
               end else if (tx_enable) begin
                  // A coincident baud_tick is deliberately ignored here: the
                  // start bit simply lasts until the next tick.
                  shadow_data <= tx_data;
                  shadow_cfg  <= cfg_reg;
                  bit_cnt     <= 3'd0;
                  tx          <= 1'b0;
                  tx_busy     <= 1'b1;
                  tx_done     <= 1'b0;
                  state       <= S_START;
               end else begin
                  tx <= 1'b1;
               end
            end
            S_START: begin
               if (baud_tick) begin
                  tx      <= shadow_data[0];
                  bit_cnt <= 3'd0;
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (baud_tick) begin
                  if (bit_cnt == last_bit) begin
                     if (shadow_cfg[3]) begin
                        tx    <= parity_bit;
                        state <= S_PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= S_STOP1;
                     end
                  end else begin
                     bit_cnt <= next_cnt;
                     tx      <= shadow_data[next_cnt];
                  end
               end
            end
            S_PARITY: begin
               if (baud_tick) begin
                  tx    <= 1'b1;
                  state <= S_STOP1;
               end
            end
            S_STOP1: begin
               if (baud_tick) begin
                  tx <= 1'b1;
                  if (shadow_cfg[2]) begin
                     state <= S_STOP2;
                  end else begin
                     tx_busy <= 1'b0;
                     tx_done <= 1'b1;
                     state   <= S_IDLE;
                  end
               end
            end
            S_STOP2: begin
               if (baud_tick) begin
                  tx      <= 1'b1;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: table of frames with hand-computed bit
// sequences, plus directed sequences for idle ticks and mid-frame reset.

module tb_uart_tx_frame;

   logic       clk;
   logic       rst_n;
   logic       baud_tick;
   logic       tx_enable;
   logic [4:0] cfg_reg;
   logic [7:0] tx_data;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;
`ifdef UART_TX_BREAK_EN
   logic       tx_break;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   uart_tx_frame dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .baud_tick (baud_tick),
      .tx_enable (tx_enable),
      .cfg_reg   (cfg_reg),
      .tx_data   (tx_data),
`ifdef UART_TX_BREAK_EN
      .tx_break  (tx_break),
`endif
      .tx        (tx),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mode: 0 plain, 1 disturb inputs mid-frame, 2 baud_tick coincident with accept.
   // exp_bits: frame bits in transmit order, first bit leftmost.
   typedef struct {
      logic [4:0]  cfg;
      logic [7:0]  data;
      int          mode;
      int          exp_n;
      logic [11:0] exp_bits;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v);
      int          n;
      logic [11:0] bits;
      logic        busy_ok;
      logic        finished;
      n        = 0;
      bits     = '0;
      busy_ok  = 1'b1;
      finished = 1'b0;
      @(negedge clk);
      tx_data   = v.data;
      cfg_reg   = v.cfg;
      tx_enable = 1'b1;
      baud_tick = (v.mode == 2);
      @(negedge clk);
      tx_enable = 1'b0;
      baud_tick = 1'b0;
      chk("accept_tx", {31'd0, tx}, 32'd0);
      chk("accept_busy", {31'd0, tx_busy}, 32'd1);
      chk("accept_done", {31'd0, tx_done}, 32'd0);
      for (int t = 0; t < 20 && !finished; t++) begin
         for (int g = 0; g < 3; g++) begin
            if (v.mode == 1 && t == 3 && g == 1) begin
               tx_enable = 1'b1;
               tx_data   = ~v.data;
               cfg_reg   = ~v.cfg;
            end else begin
               tx_enable = 1'b0;
            end
            if (!tx_busy) busy_ok = 1'b0;
            @(negedge clk);
         end
         tx_enable = 1'b0;
         baud_tick = 1'b1;
         if (tx_busy) begin
            bits = {bits[10:0], tx};
            n++;
         end
         @(negedge clk);
         baud_tick = 1'b0;
         if (!tx_busy) finished = 1'b1;
      end
      chk("frame_end_seen", {31'd0, finished}, 32'd1);
      chk("tick_count", n, v.exp_n);
      chk("bits", {20'd0, bits}, {20'd0, v.exp_bits});
      chk("busy_held", {31'd0, busy_ok}, 32'd1);
      chk("done_after", {31'd0, tx_done}, 32'd1);
      chk("tx_idle_after", {31'd0, tx}, 32'd1);
   endtask

   task automatic tick_after(input int gap);
      for (int g = 0; g < gap; g++) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
   endtask

   initial begin
      vecs[0] = '{cfg: 5'b00011, data: 8'hA5, mode: 0, exp_n: 10, exp_bits: 12'b0101001011};
      vecs[1] = '{cfg: 5'b01010, data: 8'h53, mode: 0, exp_n: 10, exp_bits: 12'b0110010101};
      vecs[2] = '{cfg: 5'b11111, data: 8'h3C, mode: 0, exp_n: 12, exp_bits: 12'b000111100111};
      vecs[3] = '{cfg: 5'b00100, data: 8'h0F, mode: 0, exp_n: 8,  exp_bits: 12'b01111011};
      vecs[4] = '{cfg: 5'b11001, data: 8'h2D, mode: 2, exp_n: 9,  exp_bits: 12'b010110111};
      vecs[5] = '{cfg: 5'b00011, data: 8'hA5, mode: 1, exp_n: 10, exp_bits: 12'b0101001011};

      rst_n     = 1'b0;
      baud_tick = 1'b0;
      tx_enable = 1'b0;
      cfg_reg   = 5'd0;
      tx_data   = 8'd0;
`ifdef UART_TX_BREAK_EN
      tx_break  = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, tx_busy}, 32'd0);
      chk("rst_done", {31'd0, tx_done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Ticks while idle must not start anything.
      tick_after(1);
      tick_after(1);
      chk("idle_tick_tx", {31'd0, tx}, 32'd1);
      chk("idle_tick_busy", {31'd0, tx_busy}, 32'd0);

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i]);
      end

      // Idle ticks after a frame leave done asserted.
      tick_after(2);
      chk("done_held_tx", {31'd0, tx}, 32'd1);
      chk("done_held_busy", {31'd0, tx_busy}, 32'd0);
      chk("done_held", {31'd0, tx_done}, 32'd1);

      // Reset in the middle of the data bits: zero data keeps tx low there.
      @(negedge clk);
      tx_data   = 8'h00;
      cfg_reg   = 5'b00011;
      tx_enable = 1'b1;
      @(negedge clk);
      tx_enable = 1'b0;
      tick_after(2);
      tick_after(2);
      tick_after(2);
      chk("mid_data_tx", {31'd0, tx}, 32'd0);
      chk("mid_data_busy", {31'd0, tx_busy}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_tx", {31'd0, tx}, 32'd1);
      chk("abort_busy", {31'd0, tx_busy}, 32'd0);
      chk("abort_done", {31'd0, tx_done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
